uart_program_loader: RTL and testbench

//  Boot-time UART program loader sitting upstream of soc_top.
//  - Receives a framed program image on a UART RX line.
//  - Packs the bytes into 32-bit words and writes them through a simple write port

---
 rtl/soc_loader_pkg.sv | 31 +++
 rtl/uart_rx_byte.sv | 102 ++++++++++
 rtl/uart_program_loader.sv | 159 +++++++++++++++
 tb/tb_uart_program_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_loader_pkg.sv
// Shared types and constants for the UART program loader.
package soc_loader_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

  // Observation bundle: both FSM states plus the running checksum.
  typedef struct packed {
    loader_state_e loader_state;
    rx_state_e     rx_state;
    logic [7:0]    csum;
  } loader_dbg_t;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam int         LOADER_LEN_W     = 16;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, falling-edge start detect
// confirmed at half a bit, mid-bit sampling, stop-bit framing check.
module uart_rx_byte
  import soc_loader_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o,
  output rx_state_e  state_o
);

  localparam int CNT_W    = $clog2(BAUD_DIV + 1);
  localparam int HALF_DIV = BAUD_DIV / 2;

  logic             rx_meta, rx_s, rx_prev;
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shreg, shreg_n;
  logic             valid_n, ferr_n;

  assign state_o   = state;
  assign rx_data_o = shreg;

  // Synchroniser and edge history; line idles high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      shreg       <= shreg_n;
      rx_valid_o  <= valid_n;
      frame_err_o <= ferr_n;
    end
  end

  // Next-state: half-bit start confirm, then one sample per bit period.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_s) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_W'(HALF_DIV - 1)) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt == CNT_W'(BAUD_DIV - 1)) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_W'(BAUD_DIV - 1)) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          valid_n = rx_s;
          ferr_n  = !rx_s;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot-time UART program loader: frame parser, word packer, memory writer,
// inter-byte timeout and core reset release.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing 8-bit sum byte).
module uart_program_loader
  import soc_loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int MEM_DEPTH      = 1024,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         uart_rx_i,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  output logic                         core_reset_o,
  output logic                         done_o,
  output logic                         error_o,
  output loader_dbg_t                  dbg_o
);

  localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int ADDR_W   = $clog2(MEM_DEPTH);
  localparam int TMR_W    = $clog2(TIMEOUT_CYCLES + 1);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e PAYLOAD_END = CSUM;
`else
  localparam loader_state_e PAYLOAD_END = DONE;
`endif

  logic        rx_valid, frame_err;
  logic [7:0]  rx_data;
  rx_state_e   rx_state;

  loader_state_e           state, state_n;
  logic [LOADER_LEN_W-1:0] len, len_n, len_full, wcnt, wcnt_n;
  logic [1:0]              byte_k, byte_k_n;
  logic [31:0]             wbuf, wbuf_n, wdata_n;
  logic [7:0]              csum, csum_n;
  logic [TMR_W-1:0]        timer, timer_n;
  logic                    we_n;
  logic [ADDR_W-1:0]       addr_n;

  assign dbg_o = '{loader_state: state, rx_state: rx_state, csum: csum};

  // rx_valid is a one-cycle pulse with rx_data valid in that cycle; there is
  // no ready: the loader consumes every byte the cycle it arrives.
  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rx_i        (uart_rx_i),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .frame_err_o (frame_err),
    .state_o     (rx_state)
  );

  // Loader registers; status outputs follow the state being entered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= SYNC;
      len          <= '0;
      wcnt         <= '0;
      byte_k       <= '0;
      wbuf         <= '0;
      csum         <= '0;
      timer        <= '0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      core_reset_o <= 1'b1;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      wcnt         <= wcnt_n;
      byte_k       <= byte_k_n;
      wbuf         <= wbuf_n;
      csum         <= csum_n;
      timer        <= timer_n;
      mem_we_o     <= we_n;
      mem_addr_o   <= addr_n;
      mem_wdata_o  <= wdata_n;
      core_reset_o <= (state_n != DONE);
      done_o       <= (state_n == DONE);
      error_o      <= (state_n == ERROR);
    end
  end

  // Frame parser: sync, length, packed payload words, optional checksum.
  always_comb begin
    state_n  = state;
    len_n    = len;
    wcnt_n   = wcnt;
    byte_k_n = byte_k;
    wbuf_n   = wbuf;
    csum_n   = csum;
    timer_n  = '0;
    we_n     = 1'b0;
    addr_n   = mem_addr_o;
    wdata_n  = mem_wdata_o;
    len_full = {rx_data, len[7:0]};
    case (state)
      SYNC: begin
        if (rx_valid && rx_data == LOADER_SYNC_BYTE) begin
          state_n  = LEN0;
          wcnt_n   = '0;
          byte_k_n = '0;
          csum_n   = '0;
        end
      end
      DONE, ERROR: ;
      default: begin
        if (frame_err) begin
          state_n = ERROR;
        end else if (rx_valid) begin
          csum_n = csum + rx_data;
          case (state)
            LEN0: begin
              len_n   = {8'h00, rx_data};
              state_n = LEN1;
            end
            LEN1: begin
              len_n = len_full;
              if (len_full == '0)                               state_n = PAYLOAD_END;
              else if (len_full > LOADER_LEN_W'(MEM_DEPTH))     state_n = ERROR;
              else                                              state_n = DATA;
            end
            DATA: begin
              wbuf_n[{byte_k, 3'b000} +: 8] = rx_data;
              byte_k_n = byte_k + 1'b1;
              if (byte_k == 2'd3) begin
                we_n    = 1'b1;
                addr_n  = wcnt[ADDR_W-1:0];
                wdata_n = wbuf_n;
                wcnt_n  = wcnt + 1'b1;
                if (wcnt_n == len) state_n = PAYLOAD_END;
              end
            end
            CSUM:    state_n = (rx_data == csum) ? DONE : ERROR;
            default: state_n = ERROR;
          endcase
        end else if (timer == TMR_W'(TIMEOUT_CYCLES)) begin
          // Stalled sender: resynchronise; words already written stay.
          state_n  = SYNC;
          wcnt_n   = '0;
          byte_k_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serial byte driver, write monitor,
// frame-level reference model and directed plus randomized frames.
module tb_uart_program_loader;
  import soc_loader_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 1024;
  localparam int TMO    = 500;
  localparam int AW     = $clog2(DEPTH);
  localparam int W      = AW + 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           uart_rx = 1'b1;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [31:0]    mem_wdata;
  logic           core_reset, done, error;
  loader_dbg_t    dbg;

  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   wr_q[$];
  logic [7:0]     stim_q[$];
  int             n_pass = 0;
  int             n_total = 0;
  int             wr_base = 0;
  int             multi_we = 0;
  int             multi_base = 0;
  logic           prev_we = 1'b0;

  uart_program_loader #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .reset_i(reset), .uart_rx_i(uart_rx),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .core_reset_o(core_reset), .done_o(done), .error_o(error), .dbg_o(dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write monitor: logs every strobe and counts strobes longer than a cycle.
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
    if (mem_we && prev_we) multi_we <= multi_we + 1;
    prev_we <= mem_we;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset      = 1'b0;
    wr_base    = wr_q.size();
    multi_base = multi_we;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = !bad_stop;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(1, 20)) @(negedge clk);
  endtask

  task automatic send_frame();
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b0);
    repeat (40) @(negedge clk);
  endtask

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[i]) stim_q.push_back(b[i]);
  endtask

  // Appends the 8-bit sum of every byte after the sync byte when the
  // checksum build is in use.
  task automatic append_csum();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s = 8'h00;
    int i = 0;
    while (stim_q[i] != 8'hA5) i++;
    for (int k = i + 1; k < stim_q.size(); k++) s = s + stim_q[k];
    stim_q.push_back(s);
`endif
  endtask

  // Reference model: parse the byte stream as a frame and list the writes.
  task automatic run_model(output bit exp_done, output bit exp_err);
    int i, len, p;
    logic [7:0]  sum;
    logic [31:0] w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    i = 0;
    while (i < stim_q.size() && stim_q[i] != 8'hA5) i++;
    if (i + 2 >= stim_q.size()) return;
    len = int'(stim_q[i+1]) + 256 * int'(stim_q[i+2]);
    sum = stim_q[i+1] + stim_q[i+2];
    if (len > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int n = 0; n < len; n++) begin
      p = i + 3 + 4 * n;
      w = {stim_q[p+3], stim_q[p+2], stim_q[p+1], stim_q[p]};
      sum = sum + stim_q[p] + stim_q[p+1] + stim_q[p+2] + stim_q[p+3];
      exp_q.push_back({AW'(n), w});
    end
`ifdef LOADER_CHECKSUM_EN
    exp_done = (stim_q[i + 3 + 4 * len] == sum);
    exp_err  = !exp_done;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic check_frame(input string tag);
    bit ed, ee;
    int nw;
    logic [W-1:0] e;
    run_model(ed, ee);
    nw = wr_q.size() - wr_base;
    check({tag, " write count"}, 64'(nw), 64'(exp_q.size()));
    for (int k = 0; k < nw && exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s write %0d", tag, k), 64'(wr_q[wr_base + k]), 64'(e));
    end
    check({tag, " done"}, 64'(done), 64'(ed));
    check({tag, " error"}, 64'(error), 64'(ee));
    check({tag, " core_reset"}, 64'(core_reset), 64'(!ed));
    check({tag, " strobe width"}, 64'(multi_we - multi_base), 64'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " we"}, 64'(mem_we), 64'(0));
    check({tag, " addr"}, 64'(mem_addr), 64'(0));
    check({tag, " wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, " core_reset"}, 64'(core_reset), 64'(1));
    check({tag, " done"}, 64'(done), 64'(0));
    check({tag, " error"}, 64'(error), 64'(0));
    check({tag, " state"}, 64'(dbg.loader_state), 64'(SYNC));
  endtask

  initial begin
    int len;
    logic [7:0] g;

    // Reset values.
    do_reset();
    check_reset_values("reset");

    // Directed normal load.
    stim_q.delete();
    push_bytes('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    append_csum();
    send_frame();
    check_frame("normal");

    // Traffic after DONE is ignored.
    wr_base = wr_q.size();
    stim_q.delete();
    push_bytes('{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b0);
    repeat (40) @(negedge clk);
    check("post-done writes", 64'(wr_q.size() - wr_base), 64'(0));
    check("post-done done", 64'(done), 64'(1));

    // Garbage before sync.
    do_reset();
    stim_q.delete();
    push_bytes('{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11});
    append_csum();
    send_frame();
    check_frame("garbage");

    // Length overflow.
    do_reset();
    stim_q.delete();
    push_bytes('{8'hA5, 8'h01, 8'h04});
    send_frame();
    check_frame("overflow");

    // Randomized frames with random non-sync prefixes.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      stim_q.delete();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom_range(0, 255));
        stim_q.push_back((g == 8'hA5) ? 8'h5A : g);
      end
      len = $urandom_range(1, 4);
      stim_q.push_back(8'h01 * 8'(len));
      stim_q.push_back(8'h00);
      stim_q.insert(stim_q.size() - 2, 8'hA5);
      repeat (4 * len) stim_q.push_back(8'($urandom_range(0, 255)));
      append_csum();
      send_frame();
      check_frame($sformatf("random%0d", r));
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    stim_q.delete();
    push_bytes('{8'hA5, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0B});
    send_frame();
    check_frame("csum good");
    do_reset();
    stim_q.delete();
    push_bytes('{8'hA5, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h0C});
    send_frame();
    check_frame("csum bad");
`endif

    // Stall mid-word, then a full frame must load from address 0.
    do_reset();
    stim_q.delete();
    push_bytes('{8'hA5, 8'h02, 8'h00, 8'h99, 8'h88});
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b0);
    repeat (TMO + 50) @(negedge clk);
    check("timeout state", 64'(dbg.loader_state), 64'(SYNC));
    check("timeout writes", 64'(wr_q.size() - wr_base), 64'(0));
    check("timeout error", 64'(error), 64'(0));
    stim_q.delete();
    push_bytes('{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11});
    append_csum();
    send_frame();
    check_frame("after timeout");

    // Reset pulse mid-frame after one word was written.
    do_reset();
    stim_q.delete();
    push_bytes('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b0);
    repeat (20) @(negedge clk);
    check("midreset pre wdata", 64'(mem_wdata), 64'h44332211);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midreset");

    // Framing error before sync is ignored.
    do_reset();
    send_byte(8'h00, 1'b1);
    stim_q.delete();
    push_bytes('{8'hA5, 8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA});
    append_csum();
    send_frame();
    check_frame("ferr in sync");

    // Framing error inside a frame is fatal to the load.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (40) @(negedge clk);
    check("ferr frame error", 64'(error), 64'(1));
    check("ferr frame core_reset", 64'(core_reset), 64'(1));
    check("ferr frame done", 64'(done), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
